// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and small helpers for lane alignment.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } dsize_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int CNT_W = 4;

  function automatic logic size_err(input dsize_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return lane[0];
      SZ_W:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input dsize_t size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return 4'b0011 << lane;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous word array with per-byte write enables and a
// registered (1-cycle) read. Contents are not reset.
module dmem_ram #(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: latches a request, waits LATENCY
// cycles, then strobes dready_n with aligned load data or an error.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [31:0] daddr,
  input  logic [1:0]  dsize,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        dready_n,
  output logic        dbusy,
  output logic        derr
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  dsize_t            l_size;
  logic [1:0]        l_lane;
  logic              l_write;
  logic              l_err;
  logic [31:0]       l_wdata;
  logic [AW-1:0]     l_index;

  logic [29:0]       req_index;
  logic              req_err;
  logic [AW-1:0]     ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_q;

  assign req_index = 30'((daddr - BASE_ADDR) >> 2);
  assign req_err   = size_err(dsize_t'(dsize), daddr[1:0]) || (req_index >= DEPTH_LIM);

  // The RAM read is registered, so the accept cycle must present the live
  // address; afterwards the latched index keeps the read stable until RESP.
  assign ram_addr = (state == IDLE) ? req_index[AW-1:0] : l_index;
  assign ram_we   = (state == RESP) && l_write && !l_err;
  assign ram_be   = byte_en(l_size, l_lane);

  always_comb begin
    ram_wdata = l_wdata;
    case (l_size)
      SZ_B:    ram_wdata = {4{l_wdata[7:0]}};
      SZ_H:    ram_wdata = {2{l_wdata[15:0]}};
      default: ram_wdata = l_wdata;
    endcase
  end

  assign rdata = ((state == RESP) && !l_write && !l_err) ? (ram_q >> {l_lane, 3'b000}) : 32'h0;
  assign dbusy = !rst && (((state == IDLE) && dreq) || (state == WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dready_n <= 1'b1;
      derr     <= 1'b0;
      l_size   <= SZ_B;
      l_lane   <= 2'b00;
      l_write  <= 1'b0;
      l_err    <= 1'b0;
      l_wdata  <= '0;
      l_index  <= '0;
    end else begin
      case (state)
        IDLE: begin
          dready_n <= 1'b1;
          derr     <= 1'b0;
          if (dreq) begin
            l_size  <= dsize_t'(dsize);
            l_lane  <= daddr[1:0];
            l_write <= dwrite;
            l_err   <= req_err;
            l_wdata <= wdata;
            l_index <= req_index[AW-1:0];
            cnt     <= CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state    <= RESP;
              dready_n <= 1'b0;
              derr     <= req_err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) begin
            state    <= RESP;
            dready_n <= 1'b0;
            derr     <= l_err;
          end
        end
        RESP: begin
          state    <= IDLE;
          dready_n <= 1'b1;
          derr     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          dready_n <= 1'b1;
          derr     <= 1'b0;
        end
      endcase
    end
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized accesses
// checked against a byte-level memory model.
module tb_dmem_responder;

  localparam int LAT2 = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dreq1, dreq2, dwrite;
  logic [31:0] daddr, wdata;
  logic [1:0]  dsize;
  logic [31:0] rdata1, rdata2;
  logic        dready_n1, dready_n2, dbusy1, dbusy2, derr1, derr2;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(LAT2), .BASE_ADDR(32'h0)) dut2 (
    .clk(clk), .rst(rst), .dreq(dreq2), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .wdata(wdata), .rdata(rdata2), .dready_n(dready_n2),
    .dbusy(dbusy2), .derr(derr2)
  );

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1), .BASE_ADDR(32'h0)) dut1 (
    .clk(clk), .rst(rst), .dreq(dreq1), .dwrite(dwrite), .daddr(daddr),
    .dsize(dsize), .wdata(wdata), .rdata(rdata1), .dready_n(dready_n1),
    .dbusy(dbusy1), .derr(derr1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on the LATENCY=2 instance; inputs are scrambled after
  // accept so only latched values can produce the expected response.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_err, input bit rst_resp, input string tag);
    int lat = 0;
    dwrite = wr; daddr = addr; dsize = sz; wdata = wd; dreq2 = 1'b1;
    #1;
    chk({tag, "_busy_acc"}, 32'(dbusy2), 32'd1);
    chk({tag, "_rdyn_acc"}, 32'(dready_n2), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      daddr = $urandom; wdata = $urandom;
      dsize = 2'($urandom); dwrite = 1'($urandom);
      #1;
      if (dready_n2 == 1'b0) begin
        lat = k;
        break;
      end
      chk({tag, "_busy_wait"}, 32'(dbusy2), 32'd1);
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT2));
    if (lat != 0) begin
      chk({tag, "_busy_resp"}, 32'(dbusy2), 32'd0);
      chk({tag, "_derr"}, 32'(derr2), 32'(exp_err));
      chk({tag, "_rdata"}, rdata2, exp_rd);
    end
    if (rst_resp) begin
      rst = 1'b1;
      #1;
      chk({tag, "_rst_rdyn"}, 32'(dready_n2), 32'd1);
      chk({tag, "_rst_busy"}, 32'(dbusy2), 32'd0);
      chk({tag, "_rst_derr"}, 32'(derr2), 32'd0);
      chk({tag, "_rst_rdata"}, rdata2, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      dreq2 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Three back-to-back word accesses on the LATENCY=1 instance with dreq held.
  task automatic b2b(input bit wr, input logic [2:0][31:0] a, input logic [2:0][31:0] wd,
                     input logic [2:0][31:0] exp, input string tag);
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) begin
        dwrite = wr; daddr = a[c/2]; dsize = 2'b10; wdata = wd[c/2]; dreq1 = 1'b1;
      end
      #1;
      chk($sformatf("%s_rdyn_c%0d", tag, c), 32'(dready_n1), (c % 2 == 1) ? 32'd0 : 32'd1);
      chk($sformatf("%s_busy_c%0d", tag, c), 32'(dbusy1), (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c % 2 == 1) begin
        chk($sformatf("%s_rdata_c%0d", tag, c), rdata1, exp[c/2]);
        chk($sformatf("%s_derr_c%0d", tag, c), 32'(derr1), 32'd0);
      end
      if (c == 5) dreq1 = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, "_idle_busy"}, 32'(dbusy1), 32'd0);
    chk({tag, "_idle_rdyn"}, 32'(dready_n1), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0][31:0] ba, bd, bz;
    rst = 1'b1; dreq1 = 1'b1; dreq2 = 1'b1; dwrite = 1'b0;
    daddr = '0; wdata = '0; dsize = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdyn", 32'(dready_n2), 32'd1);
    chk("rst_busy", 32'(dbusy2), 32'd0);
    chk("rst_derr", 32'(derr2), 32'd0);
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_busy1", 32'(dbusy1), 32'd0);
    rst = 1'b0; dreq1 = 1'b0; dreq2 = 1'b0;
    @(posedge clk); #1;

    txn(1, 32'h10, 2'b10, 32'hDEADBEEF, 32'h0, 1'b0, 0, "st_deadbeef");
    txn(0, 32'h10, 2'b10, 32'h0, 32'hDEADBEEF, 1'b0, 0, "ld_deadbeef");

    txn(1, 32'h10, 2'b10, 32'h11223344, 32'h0, 1'b0, 0, "st_11223344");
    txn(1, 32'h13, 2'b00, 32'hFFFFFFA5, 32'h0, 1'b0, 0, "st_byte_a5");
    txn(0, 32'h10, 2'b10, 32'h0, 32'hA5223344, 1'b0, 0, "ld_word_merge");
    txn(0, 32'h13, 2'b00, 32'h0, 32'h000000A5, 1'b0, 0, "ld_byte_a5");

    txn(0, 32'h11, 2'b01, 32'h0, 32'h0, 1'b1, 0, "ld_half_odd");
    txn(1, 32'h0, 2'b10, 32'h0BADC0DE, 32'h0, 1'b0, 0, "st_word0");
    txn(1, 32'h4000, 2'b10, 32'hFFFFFFFF, 32'h0, 1'b1, 0, "st_oob");
    txn(0, 32'h0, 2'b10, 32'h0, 32'h0BADC0DE, 1'b0, 0, "ld_word0");
    txn(0, 32'h4000, 2'b10, 32'h0, 32'h0, 1'b1, 0, "ld_oob");
    txn(0, 32'h12, 2'b11, 32'h0, 32'h0, 1'b1, 0, "ld_size11");

    txn(1, 32'h20, 2'b10, 32'h12345678, 32'h0, 1'b0, 0, "st_old20");
    txn(1, 32'h20, 2'b10, 32'hCAFEF00D, 32'h0, 1'b0, 1, "st_cafe_rst");
    txn(0, 32'h20, 2'b10, 32'h0, 32'h12345678, 1'b0, 0, "ld_after_rst");

    ba = {32'h8, 32'h4, 32'h0};
    bd = {$urandom, $urandom, $urandom};
    bz = '0;
    b2b(1, ba, bd, bz, "b2b_st");
    b2b(0, ba, bz, bd, "b2b_ld");

    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w = $urandom;
      txn(1, 32'(i * 4), 2'b10, w, 32'h0, 1'b0, 0, "init");
      model[i] = w;
    end
    for (int n = 0; n < 60; n++) begin
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_rd;
      logic        err;
      int          idx, lane;
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 63));
      wd = $urandom;
      idx  = int'(a) / 4;
      lane = int'(a) % 4;
      err = (sz == 2'd3) || (sz == 2'd1 && (lane % 2) == 1) || (sz == 2'd2 && lane != 0);
      exp_rd = 32'h0;
      if (!err && !wr) exp_rd = model[idx] >> (8 * lane);
      txn(wr, a, sz, wd, exp_rd, err, 0, $sformatf("rnd%0d", n));
      if (!err && wr) begin
        case (sz)
          2'd0:    model[idx][8*lane +: 8] = wd[7:0];
          2'd1:    model[idx][8*lane +: 16] = wd[15:0];
          default: model[idx] = wd;
        endcase
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
